// File: rtl/game_ctrl.sv
// Pong match sequencer: scores, game state, ball run/serve control paced by refresh_tick.
// Optional GAME_PAUSE_EN adds a pause port and a paused flag that holds the ball in PLAY.
module game_ctrl #(
  parameter int WIN_SCORE    = 5,
  parameter int SERVE_FRAMES = 60,
  parameter int SCORE_W      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               refresh_tick,
  input  logic               start,
  input  logic               miss_left,
  input  logic               miss_right,
`ifdef GAME_PAUSE_EN
  input  logic               pause,
`endif
  output logic               ball_run,
  output logic               ball_serve,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         state
);

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [SCORE_W-1:0] r_score1, r_score2;
  logic               r_ball_run, r_ball_serve, r_serve_dir, r_game_over, r_winner;
  logic [SCORE_W-1:0] w_s1_inc, w_s2_inc;
  logic               w_paused, w_miss;

`ifdef GAME_PAUSE_EN
  logic r_paused;
  assign w_paused = r_paused;
`else
  assign w_paused = 1'b0;
`endif

  assign w_s1_inc = r_score1 + 1'b1;
  assign w_s2_inc = r_score2 + 1'b1;
  assign w_miss   = (miss_left | miss_right) & ~w_paused;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_score1     <= '0;
      r_score2     <= '0;
      r_ball_run   <= 1'b0;
      r_ball_serve <= 1'b0;
      r_serve_dir  <= 1'b0;
      r_game_over  <= 1'b0;
      r_winner     <= 1'b0;
`ifdef GAME_PAUSE_EN
      r_paused     <= 1'b0;
`endif
    end else begin
      r_ball_serve <= 1'b0;
      case (r_state)
        S_IDLE, S_OVER: begin
          if (start) begin
            r_state      <= S_SERVE;
            r_score1     <= '0;
            r_score2     <= '0;
            r_serve_dir  <= 1'b0;
            r_cnt        <= '0;
            r_ball_serve <= 1'b1;
            r_game_over  <= 1'b0;
            r_winner     <= 1'b0;
          end
        end
        S_SERVE: begin
          if (refresh_tick) begin
            if (r_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
              r_state    <= S_PLAY;
              r_ball_run <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_PLAY: begin
          // refresh_tick is deliberately ignored here, so a tick coincident with a miss is lost
          if (w_miss) begin
            r_ball_run <= 1'b0;
            if (miss_left && miss_right) begin
              r_state <= S_POINT;
            end else if (miss_left) begin
              r_score2    <= w_s2_inc;
              r_serve_dir <= 1'b0;
              if (w_s2_inc == SCORE_W'(WIN_SCORE)) begin
                r_state     <= S_OVER;
                r_game_over <= 1'b1;
                r_winner    <= 1'b1;
              end else begin
                r_state <= S_POINT;
              end
            end else begin
              r_score1    <= w_s1_inc;
              r_serve_dir <= 1'b1;
              if (w_s1_inc == SCORE_W'(WIN_SCORE)) begin
                r_state     <= S_OVER;
                r_game_over <= 1'b1;
                r_winner    <= 1'b0;
              end else begin
                r_state <= S_POINT;
              end
            end
          end
`ifdef GAME_PAUSE_EN
          else if (pause) begin
            r_paused   <= ~r_paused;
            r_ball_run <= r_paused;
          end
`endif
        end
        S_POINT: begin
          if (refresh_tick) begin
            r_state      <= S_SERVE;
            r_cnt        <= '0;
            r_ball_serve <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ball_run   = r_ball_run;
  assign ball_serve = r_ball_serve;
  assign serve_dir  = r_serve_dir;
  assign score1     = r_score1;
  assign score2     = r_score2;
  assign game_over  = r_game_over;
  assign winner     = r_winner;
  assign state      = r_state;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with WIN_SCORE=3, SERVE_FRAMES=4.
module tb_game_ctrl;
  logic       clk, reset, refresh_tick, start, miss_left, miss_right;
  logic       pause;
  logic       ball_run, ball_serve, serve_dir, game_over, winner;
  logic [3:0] score1, score2;
  logic [2:0] state;
  int total = 0;
  int bad   = 0;

  game_ctrl #(.WIN_SCORE(3), .SERVE_FRAMES(4), .SCORE_W(4)) dut (
    .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .start(start),
    .miss_left(miss_left), .miss_right(miss_right),
`ifdef GAME_PAUSE_EN
    .pause(pause),
`endif
    .ball_run(ball_run), .ball_serve(ball_serve), .serve_dir(serve_dir),
    .score1(score1), .score2(score2), .game_over(game_over), .winner(winner),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task cyc;
    @(posedge clk); #1;
  endtask

  task tick;
    refresh_tick = 1'b1; cyc(); refresh_tick = 1'b0;
  endtask

  task do_start;
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task do_miss(input logic l, input logic r);
    miss_left = l; miss_right = r; cyc(); miss_left = 1'b0; miss_right = 1'b0;
  endtask

  task to_play;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task test_reset;
    #2;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state); end
    total++; if ({ball_run, ball_serve, serve_dir, game_over, winner} !== 5'b0) begin bad++; $display("FAIL rst_flags got=%b exp=00000", {ball_run, ball_serve, serve_dir, game_over, winner}); end
    total++; if ({score1, score2} !== 8'h00) begin bad++; $display("FAIL rst_scores got=%h exp=00", {score1, score2}); end
    @(negedge clk); reset = 1'b1; cyc();
    total++; if (state !== 3'd0) begin bad++; $display("FAIL idle_hold got=%0d exp=0", state); end
  endtask

  task test_start_serve;
    do_start();
    total++; if (ball_serve !== 1'b1) begin bad++; $display("FAIL start_serve got=%b exp=1", ball_serve); end
    total++; if (state !== 3'd1) begin bad++; $display("FAIL start_state got=%0d exp=1", state); end
    cyc();
    total++; if (ball_serve !== 1'b0) begin bad++; $display("FAIL serve_pulse_len got=%b exp=0", ball_serve); end
    for (int i = 0; i < 3; i++) tick();
    total++; if ({state, ball_run} !== {3'd1, 1'b0}) begin bad++; $display("FAIL serve_3ticks got=%0d/%b exp=1/0", state, ball_run); end
    tick();
    total++; if ({state, ball_run} !== {3'd2, 1'b1}) begin bad++; $display("FAIL play_entry got=%0d/%b exp=2/1", state, ball_run); end
  endtask

  task test_point;
    do_miss(1'b0, 1'b1);
    total++; if ({score1, score2} !== 8'h10) begin bad++; $display("FAIL point_score got=%h exp=10", {score1, score2}); end
    total++; if ({serve_dir, ball_run, state} !== {1'b1, 1'b0, 3'd3}) begin bad++; $display("FAIL point_state got=%b/%b/%0d exp=1/0/3", serve_dir, ball_run, state); end
    tick();
    total++; if ({state, ball_serve} !== {3'd1, 1'b1}) begin bad++; $display("FAIL point_reserve got=%0d/%b exp=1/1", state, ball_serve); end
  endtask

  task test_win;
    // first rally: tick coincident with the miss must not release POINT
    to_play();
    refresh_tick = 1'b1; do_miss(1'b1, 1'b0); refresh_tick = 1'b0;
    cyc();
    total++; if ({state, score2} !== {3'd3, 4'd1}) begin bad++; $display("FAIL tick_with_miss got=%0d/%0d exp=3/1", state, score2); end
    tick();
    total++; if (state !== 3'd1) begin bad++; $display("FAIL later_tick got=%0d exp=1", state); end
    to_play(); do_miss(1'b1, 1'b0); tick();
    to_play(); do_miss(1'b1, 1'b0);
    total++; if ({score1, score2} !== 8'h13) begin bad++; $display("FAIL win_score got=%h exp=13", {score1, score2}); end
    total++; if ({state, game_over, winner, ball_run} !== {3'd4, 1'b1, 1'b1, 1'b0}) begin bad++; $display("FAIL win_over got=%0d/%b/%b/%b exp=4/1/1/0", state, game_over, winner, ball_run); end
    do_miss(1'b1, 1'b0); do_miss(1'b0, 1'b1); tick();
    total++; if ({score1, score2, state} !== {4'd1, 4'd3, 3'd4}) begin bad++; $display("FAIL over_frozen got=%0d/%0d/%0d exp=1/3/4", score1, score2, state); end
  endtask

  task test_over_restart;
    do_start();
    total++; if ({score1, score2} !== 8'h00) begin bad++; $display("FAIL restart_scores got=%h exp=00", {score1, score2}); end
    total++; if ({state, ball_serve, game_over, winner, serve_dir} !== {3'd1, 1'b1, 1'b0, 1'b0, 1'b0}) begin bad++; $display("FAIL restart_flags got=%0d/%b/%b/%b/%b exp=1/1/0/0/0", state, ball_serve, game_over, winner, serve_dir); end
  endtask

  task test_both_miss;
    to_play(); do_miss(1'b0, 1'b1); tick(); to_play();
    do_miss(1'b1, 1'b1);
    total++; if ({score1, score2, serve_dir} !== {4'd1, 4'd0, 1'b1}) begin bad++; $display("FAIL both_scores got=%0d/%0d/%b exp=1/0/1", score1, score2, serve_dir); end
    total++; if ({state, ball_run} !== {3'd3, 1'b0}) begin bad++; $display("FAIL both_state got=%0d/%b exp=3/0", state, ball_run); end
    tick(); cyc(); do_start();
    total++; if ({state, ball_serve, score1} !== {3'd1, 1'b0, 4'd1}) begin bad++; $display("FAIL start_in_serve got=%0d/%b/%0d exp=1/0/1", state, ball_serve, score1); end
    to_play();
    total++; if (state !== 3'd2) begin bad++; $display("FAIL serve_cnt_kept got=%0d exp=2", state); end
  endtask

  task test_pause;
`ifdef GAME_PAUSE_EN
    pause = 1'b1; cyc(); pause = 1'b0;
    total++; if ({state, ball_run} !== {3'd2, 1'b0}) begin bad++; $display("FAIL pause_on got=%0d/%b exp=2/0", state, ball_run); end
    do_miss(1'b1, 1'b0);
    total++; if ({state, score2} !== {3'd2, 4'd0}) begin bad++; $display("FAIL pause_miss got=%0d/%0d exp=2/0", state, score2); end
    pause = 1'b1; cyc(); pause = 1'b0;
    total++; if ({state, ball_run} !== {3'd2, 1'b1}) begin bad++; $display("FAIL pause_off got=%0d/%b exp=2/1", state, ball_run); end
`else
    tick(); cyc(); cyc();
    total++; if ({state, ball_run} !== {3'd2, 1'b1}) begin bad++; $display("FAIL play_steady got=%0d/%b exp=2/1", state, ball_run); end
`endif
  endtask

  task test_async_reset;
    #3 reset = 1'b0;
    #1;
    total++; if (state !== 3'd0) begin bad++; $display("FAIL async_state got=%0d exp=0", state); end
    total++; if ({ball_run, serve_dir, score1, score2} !== 10'b0) begin bad++; $display("FAIL async_clear got=%b/%b/%0d/%0d exp=0/0/0/0", ball_run, serve_dir, score1, score2); end
    @(negedge clk); reset = 1'b1; cyc();
  endtask

  initial begin
    reset = 1'b0; refresh_tick = 1'b0; start = 1'b0;
    miss_left = 1'b0; miss_right = 1'b0; pause = 1'b0;
    test_reset();
    test_start_serve();
    test_point();
    test_win();
    test_over_restart();
    test_both_miss();
    test_pause();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
